// File: rtl/m_call_pkg.sv
`default_nettype none
// ============================================================================
// Module  : m_call_pkg
// Purpose : Shared types and elaboration-time helpers for the round-robin
//           call scheduler (state encoding, call-unit offset, index widths).
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package m_call_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } call_state_e;

  // Constant added by the call unit; evaluated at elaboration.
  function automatic int get_offset(input int v);
    return v + 1;
  endfunction

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/m_call_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : m_call_rr_pick
// Purpose : Combinational round-robin picker. Selects the first asserted
//           request at or after ptr_i, wrapping past NUM_REQ-1 to 0.
// Ports   : req_i   [NUM_REQ-1:0]  request vector
//           ptr_i   [IDW-1:0]      highest-priority index
//           grant_o [NUM_REQ-1:0]  one-hot grant
//           idx_o   [IDW-1:0]      index of the grant
//           any_o                  at least one request present
// Revision: 1.0  initial release
// ============================================================================
module m_call_rr_pick
  import m_call_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     idx_o,
  output logic               any_o
);

  // Scan offsets from farthest to nearest so the nearest valid request
  // (smallest distance from ptr_i) is the last, winning assignment.
  always_comb begin
    int j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end
      if (req_i[j]) begin
        grant_o    = '0;
        grant_o[j] = 1'b1;
        idx_o      = IDW'(j);
        any_o      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/m_call_sched_rr.sv
`default_nettype none
// ============================================================================
// Module  : m_call_sched_rr
// Purpose : Shares one multi-cycle call unit (result = arg + OFFSET) among
//           NUM_REQ requesters using round-robin arbitration, one call in
//           flight at a time.
// Ports   : clk, rst_n                 clock, async active-low reset
//           req_valid [NUM_REQ-1:0]    per-requester call request
//           req_arg   [NUM_REQ*DW-1:0] packed arguments, i at [i*DW +: DW]
//           req_ready [NUM_REQ-1:0]    one-hot grant pulse
//           rsp_valid/rsp_id/rsp_data/rsp_ovf  result to consumer
//           rsp_ready                  consumer accepts result
//           busy                       scheduler not idle
// Revision: 1.0  initial release
// ============================================================================
module m_call_sched_rr
  import m_call_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DW       = 32,
  parameter int LATENCY  = 3,
  parameter int BASE_VAL = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DW-1:0]        req_arg,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rsp_valid,
  output logic [id_width(NUM_REQ)-1:0] rsp_id,
  output logic [DW-1:0]                rsp_data,
  output logic                         rsp_ovf,
  input  logic                         rsp_ready,
  output logic                         busy
);

  localparam int             OFFSET   = get_offset(BASE_VAL);
  localparam int             IDW      = id_width(NUM_REQ);
  localparam int             CW       = id_width(LATENCY);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [DW:0]    OFF_EXT  = (DW + 1)'(OFFSET);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);

  call_state_e         state_q, state_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DW-1:0]       arg_q, arg_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [DW-1:0]       data_q, data_d;
  logic                ovf_q, ovf_d;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IDW-1:0]      pick_idx;
  logic                pick_any;
  logic [DW-1:0]       arg_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign arg_arr[i] = req_arg[i*DW +: DW];
  end

  m_call_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      count_q  <= '0;
      arg_q    <= '0;
      id_q     <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      arg_q    <= arg_d;
      id_q     <= id_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    count_d   = count_q;
    arg_d     = arg_q;
    id_d      = id_q;
    data_d    = data_q;
    ovf_d     = ovf_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_ready = pick_gnt;
          arg_d     = arg_arr[pick_idx];
          id_d      = pick_idx;
          count_d   = CNT_LOAD;
          rr_ptr_d  = (pick_idx == LAST_ID) ? '0 : pick_idx + 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        // Counter starts at LATENCY-1, so the result lands after exactly
        // LATENCY cycles in this state.
        if (count_q == '0) begin
          {ovf_d, data_d} = {1'b0, arg_q} + OFF_EXT;
          state_d         = RESP;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_m_call_sched_rr.sv
`default_nettype none
// ============================================================================
// Module  : tb_m_call_sched_rr
// Purpose : Self-checking bench for m_call_sched_rr: directed scenarios plus
//           randomized traffic compared against a transaction-level model.
// Revision: 1.0  initial release
// ============================================================================
module tb_m_call_sched_rr;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int OFF = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_arg = '0;
  logic [N-1:0]  req_ready;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [DW-1:0] rsp_data;
  logic          rsp_ovf;
  logic          rsp_ready = 1'b0;
  logic          busy;

  m_call_sched_rr #(
    .NUM_REQ  (N),
    .DW       (DW),
    .LATENCY  (LAT),
    .BASE_VAL (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_arg   (req_arg),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: one call in flight; m_wait counts execute cycles left.
  int          m_ptr  = 0;
  bit          m_idle = 1'b1;
  bit          m_resp = 1'b0;
  int          m_wait = 0;
  int          m_id   = 0;
  logic [31:0] m_data = '0;
  bit          m_ovf  = 1'b0;
  logic [N-1:0] m_gnt = '0;

  // Values sampled in the last step
  logic [N-1:0]  s_ready;
  logic          s_rv, s_ovf, s_busy;
  logic [1:0]    s_id;
  logic [DW-1:0] s_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int ref_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Inputs are driven just after a rising edge; outputs are checked on the
  // falling edge and the model advances to match the next rising edge.
  task automatic step();
    int g;
    logic [63:0] sum;
    @(negedge clk);
    if (!rst_n) begin
      m_idle = 1'b1; m_resp = 1'b0; m_ptr = 0; m_wait = 0;
    end
    g     = (m_idle && rst_n) ? ref_pick(req_valid, m_ptr) : -1;
    m_gnt = '0;
    if (g >= 0) m_gnt[g] = 1'b1;
    s_ready = req_ready; s_rv = rsp_valid; s_id = rsp_id;
    s_data  = rsp_data;  s_ovf = rsp_ovf;  s_busy = busy;
    chk("req_ready", 64'(s_ready), 64'(m_gnt));
    chk("busy", 64'(s_busy), 64'(!m_idle));
    chk("rsp_valid", 64'(s_rv), 64'(m_resp));
    if (m_resp) begin
      chk("rsp_id", 64'(s_id), 64'(m_id));
      chk("rsp_data", 64'(s_data), 64'(m_data));
      chk("rsp_ovf", 64'(s_ovf), 64'(m_ovf));
    end
    if (!rst_n) begin
      // model already reset
    end else if (g >= 0) begin
      sum    = 64'(req_arg[g*DW +: DW]) + 64'(OFF);
      m_data = sum[31:0];
      m_ovf  = sum[32];
      m_id   = g;
      m_wait = LAT;
      m_idle = 1'b0;
      m_ptr  = (g + 1) % N;
    end else if (!m_idle && !m_resp) begin
      m_wait--;
      if (m_wait == 0) m_resp = 1'b1;
    end else if (m_resp && rsp_ready) begin
      m_resp = 1'b0;
      m_idle = 1'b1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      if (!s_busy) done = 1'b1;
    end
    chk("drain_idle", 64'(done), 64'd1);
  endtask

  task automatic wait_rsp(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (s_rv) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  int          gq_idx[$];
  int          gq_cyc[$];
  int          exp_order[5] = '{0, 1, 2, 3, 0};
  logic [31:0] a;
  logic [1:0]  h_id;
  logic [31:0] h_data;
  logic        h_ovf;

  initial begin
    // Reset state
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    step();
    step();
    chk("rst_rsp_id", 64'(s_id), 64'd0);
    chk("rst_rsp_data", 64'(s_data), 64'd0);
    chk("rst_rsp_ovf", 64'(s_ovf), 64'd0);
    rst_n = 1'b1;

    // 1: idle with no requests
    for (int i = 0; i < 10; i++) step();
    chk("t1_busy", 64'(s_busy), 64'd0);

    // 2: single request from requester 2
    req_valid = 4'b0100;
    req_arg[2*DW +: DW] = 32'd10;
    rsp_ready = 1'b1;
    step();
    chk("t2_gnt", 64'(s_ready), 64'h4);
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_early_rsp", 64'(s_rv), 64'd0);
    end
    step();
    chk("t2_rsp_valid", 64'(s_rv), 64'd1);
    chk("t2_rsp_id", 64'(s_id), 64'd2);
    chk("t2_rsp_data", 64'(s_data), 64'd16);
    chk("t2_rsp_ovf", 64'(s_ovf), 64'd0);
    drain();

    // 3: all requesters continuously valid after a fresh reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) req_arg[i*DW +: DW] = $urandom;
    for (int c = 0; c < 25; c++) begin
      step();
      if (s_ready != '0) begin
        gq_idx.push_back(onehot_idx(s_ready));
        gq_cyc.push_back(c);
        req_arg[onehot_idx(s_ready)*DW +: DW] = $urandom;
      end
    end
    chk("t3_ngrants", 64'(gq_idx.size()), 64'd5);
    for (int i = 0; i < gq_idx.size() && i < 5; i++) begin
      chk("t3_order", 64'(gq_idx[i]), 64'(exp_order[i]));
      if (i > 0) chk("t3_spacing", 64'(gq_cyc[i] - gq_cyc[i-1]), 64'(LAT + 2));
    end
    drain();

    // 4: add overflow on requester 1
    req_valid = 4'b0010;
    req_arg[1*DW +: DW] = 32'hFFFF_FFFC;
    rsp_ready = 1'b1;
    step();
    chk("t4_gnt", 64'(s_ready), 64'h2);
    req_valid = '0;
    wait_rsp("t4_rsp_seen");
    chk("t4_rsp_data", 64'(s_data), 64'h2);
    chk("t4_rsp_ovf", 64'(s_ovf), 64'd1);
    drain();

    // 5: back-pressure in RESP with pending requests
    req_valid = 4'b0001;
    req_arg[0 +: DW] = $urandom;
    rsp_ready = 1'b0;
    step();
    chk("t5_gnt_wrap", 64'(s_ready), 64'h1);
    req_valid = 4'b1110;
    wait_rsp("t5_rsp_seen");
    h_id = s_id; h_data = s_data; h_ovf = s_ovf;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t5_hold_valid", 64'(s_rv), 64'd1);
      chk("t5_hold_id", 64'(s_id), 64'(h_id));
      chk("t5_hold_data", 64'(s_data), 64'(h_data));
      chk("t5_hold_ovf", 64'(s_ovf), 64'(h_ovf));
      chk("t5_no_gnt", 64'(s_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    step();
    chk("t5_accept_no_gnt", 64'(s_ready), 64'd0);
    step();
    chk("t5_next_gnt", 64'(s_ready), 64'h2);
    drain();

    // 6: reset during execute discards the call and the pointer
    req_valid = 4'b0100;
    req_arg[2*DW +: DW] = $urandom;
    step();
    chk("t6_gnt", 64'(s_ready), 64'h4);
    req_valid = '0;
    step();
    rst_n = 1'b0;
    step();
    chk("t6_rst_busy", 64'(s_busy), 64'd0);
    step();
    rst_n = 1'b1;
    req_valid = 4'b1011;
    step();
    chk("t6_gnt_after_rst", 64'(s_ready), 64'h1);
    req_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_rsp", 64'(s_rv), 64'd0);
    end
    drain();

    // Randomized traffic
    req_valid = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 99) < 30) begin
          req_valid[i] = 1'b1;
          if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFF - 32'($urandom_range(0, 8));
          else a = $urandom;
          req_arg[i*DW +: DW] = a;
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        req_valid = '0;
      end
      step();
      if (!rst_n) rst_n = 1'b1;
      req_valid = req_valid & ~m_gnt;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
